// File: rtl/rv_pkg.sv
// Shared RV32 fetch definitions: opcodes, NOP, fetch FSM states, IF/ID payload, J-immediate helper.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0]      OPC_JAL    = 7'b1101111;
  localparam logic [6:0]      OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]      OPC_JALR   = 7'b1100111;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic            pred_taken;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifid_t;

  // Sign-extended J-type immediate.
  function automatic logic [XLEN-1:0] jimm(input logic [XLEN-1:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC select: redirect, stall hold, JAL predecode (IF_JAL_PREDECODE_EN), PC+4.
module if_next_pc
  import rv_pkg::*;
(
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  input  logic [XLEN-1:0] pc_q,
`ifdef IF_JAL_PREDECODE_EN
  input  logic [XLEN-1:0] instr,
`endif
  output logic [XLEN-1:0] next_pc_c,
  output logic            pred_taken_c,
  output logic            misalign_c
);

  always_comb begin
    next_pc_c    = pc_q + 32'd4;
    pred_taken_c = 1'b0;
    misalign_c   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      next_pc_c = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (stall) begin
      next_pc_c = pc_q;
    end
`ifdef IF_JAL_PREDECODE_EN
    else if (instr[6:0] == OPC_JAL) begin
      next_pc_c    = pc_q + jimm(instr);
      pred_taken_c = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALTED FSM and IF/ID register.
// Optional JAL predecode redirect is enabled by defining IF_JAL_PREDECODE_EN.
module if_stage_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS = 64,
  parameter logic [XLEN-1:0] NOP_INSTR  = rv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] read_addr,
  input  logic [XLEN-1:0] instruction_out,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic            ifid_pred_taken,
  output logic            fetch_halted,
  output logic            misalign_fault
);

  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  ifid_t           ifid_q;
  logic [XLEN-1:0] next_pc_c;
  logic            pred_taken_c;
  logic            misalign_c;

  if_next_pc u_next_pc (
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .pc_q           (pc_q),
`ifdef IF_JAL_PREDECODE_EN
    .instr          (instruction_out),
`endif
    .next_pc_c      (next_pc_c),
    .pred_taken_c   (pred_taken_c),
    .misalign_c     (misalign_c)
  );

  // Redirect beats the range check, which beats stall, which beats capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      ifid_q         <= '{valid: 1'b0, pred_taken: 1'b0, pc: '0, instr: NOP_INSTR};
      fetch_halted   <= 1'b0;
      misalign_fault <= 1'b0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (redirect_valid) begin
            pc_q              <= next_pc_c;
            ifid_q.valid      <= 1'b0;
            ifid_q.pred_taken <= 1'b0;
            ifid_q.instr      <= NOP_INSTR;
            if (misalign_c) misalign_fault <= 1'b1;
          end else if (pc_q >= PC_LIMIT) begin
            state_q           <= HALTED;
            fetch_halted      <= 1'b1;
            ifid_q.valid      <= 1'b0;
            ifid_q.pred_taken <= 1'b0;
            ifid_q.instr      <= NOP_INSTR;
          end else if (!stall) begin
            ifid_q <= '{valid: 1'b1, pred_taken: pred_taken_c, pc: pc_q, instr: instruction_out};
            pc_q   <= next_pc_c;
          end
        end
        HALTED: begin
          if (redirect_valid) begin
            pc_q <= next_pc_c;
            if (misalign_c) misalign_fault <= 1'b1;
            if (next_pc_c < PC_LIMIT) begin
              state_q      <= RUN;
              fetch_halted <= 1'b0;
            end
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign read_addr       = pc_q;
  assign ifid_valid      = ifid_q.valid;
  assign ifid_instr      = ifid_q.instr;
  assign ifid_pc         = ifid_q.pc;
  assign ifid_pred_taken = ifid_q.pred_taken;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Self-checking bench for if_stage_fetch: vector table through an expected-value queue.
module tb_if_stage_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_JAL_PREDECODE_EN
  localparam logic [31:0] JT = 32'h84;
  localparam logic        JP = 1'b1;
`else
  localparam logic [31:0] JT = 32'h74;
  localparam logic        JP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] read_addr;
  logic [31:0] instruction_out;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_pred_taken;
  logic        fetch_halted;
  logic        misalign_fault;

  logic [31:0] mem [64];

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_pred;
    logic        e_halt;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  if_stage_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .read_addr       (read_addr),
    .instruction_out (instruction_out),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_pred_taken (ifid_pred_taken),
    .fetch_halted    (fetch_halted),
    .misalign_fault  (misalign_fault)
  );

  always #5 clk = ~clk;

  assign instruction_out = (read_addr < 32'h100) ? mem[read_addr[7:2]] : 32'hDEAD_BEEF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                              input logic [31:0] addr, input logic val, input logic [31:0] pc,
                              input logic pred, input logic halt, input logic mis);
    vec_t v;
    v.stall = st; v.rv = rv; v.rpc = rpc; v.e_addr = addr; v.e_valid = val;
    v.e_pc = pc; v.e_pred = pred; v.e_halt = halt; v.e_mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, read_addr, 32'h0);
    chk({tag, "_valid"}, 32'(ifid_valid), 32'h0);
    chk({tag, "_instr"}, ifid_instr, NOP);
    chk({tag, "_pc"}, ifid_pc, 32'h0);
    chk({tag, "_pred"}, 32'(ifid_pred_taken), 32'h0);
    chk({tag, "_halt"}, 32'(fetch_halted), 32'h0);
    chk({tag, "_mis"}, 32'(misalign_fault), 32'h0);
  endtask

  // Called at posedge+1: drive, queue expectation, compare after the next edge.
  task automatic step(input vec_t v, input string tag, input int idx);
    vec_t e;
    stall = v.stall;
    redirect_valid = v.rv;
    redirect_pc = v.rpc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s[%0d] scoreboard: queue empty", tag, idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d] read_addr", tag, idx), read_addr, e.e_addr);
      chk($sformatf("%s[%0d] ifid_valid", tag, idx), 32'(ifid_valid), 32'(e.e_valid));
      chk($sformatf("%s[%0d] ifid_pred_taken", tag, idx), 32'(ifid_pred_taken), 32'(e.e_pred));
      chk($sformatf("%s[%0d] fetch_halted", tag, idx), 32'(fetch_halted), 32'(e.e_halt));
      chk($sformatf("%s[%0d] misalign_fault", tag, idx), 32'(misalign_fault), 32'(e.e_mis));
      if (e.e_valid) begin
        chk($sformatf("%s[%0d] ifid_pc", tag, idx), ifid_pc, e.e_pc);
        chk($sformatf("%s[%0d] ifid_instr", tag, idx), ifid_instr, mem[e.e_pc[7:2]]);
      end else begin
        chk($sformatf("%s[%0d] ifid_instr", tag, idx), ifid_instr, NOP);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0033 | (32'(i) << 15);
    mem[1]  = 32'h0031_00B3;
    mem[28] = 32'h0140_00EF;

    // Boot, sequential fetch, stall, redirect under stall, misalign, halt and recovery.
    tbl.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   32'h4,   1, 32'h0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   32'h8,   1, 32'h4,  0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   32'hC,   1, 32'h8,  0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   32'h10,  1, 32'hC,  0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,   32'h10,  1, 32'hC,  0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,   32'h10,  1, 32'hC,  0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,   32'h10,  1, 32'hC,  0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   32'h14,  1, 32'h10, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h30,  32'h30,  0, 32'h0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   32'h34,  1, 32'h30, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h32,  32'h30,  0, 32'h0,  0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   32'h34,  1, 32'h30, 0, 0, 1));
    tbl.push_back(mk(0, 1, 32'hF0,  32'hF0,  0, 32'h0,  0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   32'hF4,  1, 32'hF0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   32'hF8,  1, 32'hF4, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   32'hFC,  1, 32'hF8, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   32'h100, 1, 32'hFC, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   32'h100, 0, 32'h0,  0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0,   32'h100, 0, 32'h0,  0, 1, 1));
    tbl.push_back(mk(1, 0, 32'h0,   32'h100, 0, 32'h0,  0, 1, 1));
    tbl.push_back(mk(0, 1, 32'h200, 32'h200, 0, 32'h0,  0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0,   32'h200, 0, 32'h0,  0, 1, 1));
    tbl.push_back(mk(0, 1, 32'h0,   32'h0,   0, 32'h0,  0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   32'h4,   1, 32'h0,  0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   32'h8,   1, 32'h4,  0, 0, 1));

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], "main", i);

    // Asynchronous reset while a stalled redirect is pending.
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    rst = 1'b0;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    #1;
    chk_reset("held_rst");
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    rst = 1'b1;

    // JAL x1,20 at 0x70: predecode jumps to 0x84, otherwise sequential to 0x74.
    tbl.delete();
    tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,  0,  0, 0));
    tbl.push_back(mk(0, 1, 32'h70, 32'h70,        0, 32'h0,  0,  0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  JT,            1, 32'h70, JP, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  JT + 32'h4,    1, JT,     0,  0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], "jal", i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage directly upstream of instruction_mem.
- Owns the program counter and drives read_addr. Captures the combinational instruction_out the same cycle into an IF/ID pipeline register for decode.
- Handles pipeline stall, branch/jump redirect with flush, and an out-of-range halt. Optionally predecodes JAL for zero-bubble redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 64, instruction-memory depth in words; fetch range is [0, IMEM_WORDS*4).
- NOP_INSTR, 32'h0000_0013, value placed in ifid_instr when the slot is invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect_valid  in  1  EX-resolved taken branch/jump.
- redirect_pc  in  32  target for redirect_valid.
- read_addr  out  32  byte address to instruction_mem (= pc_q).
- instruction_out  in  32  combinational data from instruction_mem.
- ifid_valid  out  1  IF/ID slot holds a real instruction.
- ifid_instr  out  32  latched instruction.
- ifid_pc  out  32  PC of latched instruction.
- ifid_pred_taken  out  1  slot was redirected by JAL predecode (0 when macro off).
- fetch_halted  out  1  FSM in HALTED.
- misalign_fault  out  1  sticky; last redirect target had [1:0]!=0.

Behaviour:
- Reset (rst=0, async): pc_q=RESET_PC, state=BOOT, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pred_taken=0, fetch_halted=0, misalign_fault=0.
- read_addr = pc_q at all times. Memory read is combinational, so fetch latency is 1 cycle from PC to IF/ID.
- FSM states and transitions:
  - BOOT: one cycle after reset release, ifid_valid stays 0; BOOT->RUN unconditionally.
  - RUN: normal fetch.
  - HALTED: entered when pc_q >= IMEM_WORDS*4 in RUN. ifid_valid=0, PC frozen, fetch_halted=1. Leaves only on redirect_valid with an in-range target.
- RUN edge, by priority:
  1. redirect_valid: pc_q<=redirect_pc with bits [1:0] forced to 0; ifid_valid<=0 (flush); ifid_instr<=NOP_INSTR. If redirect_pc[1:0]!=0, set misalign_fault (sticky until reset). Redirect overrides stall.
  2. stall: pc_q and all IF/ID outputs hold.
  3. Otherwise: ifid_instr<=instruction_out, ifid_pc<=pc_q, ifid_valid<=1, pc_q<=next_seq.
- next_seq = pc_q+4 (32-bit wrap, no carry-out), or the JAL target under the optional feature.
- Out-of-range PC in RUN: no capture; ifid_valid<=0; go to HALTED next edge.
- Redirect in HALTED with an out-of-range target: stay HALTED, pc_q updated.
- Reset mid-operation: all state returns to reset values immediately, regardless of stall or redirect.

Optional Feature:
- Macro: IF_JAL_PREDECODE_EN.
- With the macro defined:
  - In the capture case (3), if instruction_out[6:0]==7'b1101111, then next_seq = pc_q + sign-extended J-imm {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - ifid_pred_taken<=1 for that slot; execute must not re-redirect. A simultaneous redirect_valid still wins.
- Without the macro: next_seq always pc_q+4; ifid_pred_taken tied to 0.

Decomposition:
- Shared package rv_pkg:
  - OPC_JAL, OPC_BRANCH, OPC_JALR opcode constants.
  - NOP_INSTR default.
  - fetch_state_t enum {BOOT, RUN, HALTED}.
  - function jimm(inst) returning the 32-bit J-immediate.
- One natural sub-module, if_next_pc: combinational next-PC mux (redirect/stall/predecode/sequential), instanced by if_stage_fetch. The PC register, FSM and IF/ID register stay in the top.

Test Plan:
- Reset then release, memory holds add at word 1 -> cycle1 ifid_valid=0 (BOOT); then ifid_pc=0,4,8… with matching instruction words, read_addr stepping by 4.
- stall held 3 cycles at pc_q=0x10 -> read_addr stays 0x10, ifid_instr/ifid_pc unchanged; release -> resumes at 0x10.
- redirect_valid with redirect_pc=0x30 while stall=1 -> next cycle pc_q=0x30, ifid_valid=0; following cycle ifid_pc=0x30.
- Redirect to 0x32 -> pc_q=0x30, misalign_fault=1 and stays 1 until rst low.
- Sequential fetch to 0xFC then 0x100 (IMEM_WORDS=64) -> fetch_halted=1, ifid_valid=0, PC frozen; redirect to 0x0 -> back to RUN and fetch from 0.
- Macro on, JAL x1,20 at word 28 (pc 0x70) -> next read_addr=0x84, ifid_pred_taken=1 for pc 0x70; macro off -> next read_addr=0x74, ifid_pred_taken=0.
